// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and defaults for the gated frequency meter.
//   fm_state_t      - measurement FSM states (IDLE, GATE, DONE)
//   DEF_GATE_CYCLES - default gate length in sys_clk cycles (1 s at 100 MHz)
//   DEF_CNT_W       - default edge counter / result width
//   SYNC_STAGES     - synchronizer depth ahead of the edge-history flop
//   gate_cnt_w()    - width of the gate counter for a given gate length
package freq_meter_pkg;

  typedef enum logic [1:0] {IDLE, GATE, DONE} fm_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 100000000;
  localparam int unsigned DEF_CNT_W       = 28;
  localparam int unsigned SYNC_STAGES     = 2;

  function automatic int unsigned gate_cnt_w(input int unsigned gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: control/result bundle of the frequency meter.
//   start, cont                         - host requests (single / continuous)
//   busy, freq_out, freq_valid, overflow - meter status and result
//   high_cnt                            - high-level cycle count (FREQ_METER_DUTY_EN only)
// Modports: master = host side, slave = meter side.
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             cont;
  logic             busy;
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             overflow;
`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] high_cnt;

  modport master (output start, cont, input busy, freq_out, freq_valid, overflow, high_cnt);
  modport slave  (input start, cont, output busy, freq_out, freq_valid, overflow, high_cnt);
`else
  modport master (output start, cont, input busy, freq_out, freq_valid, overflow);
  modport slave  (input start, cont, output busy, freq_out, freq_valid, overflow);
`endif

endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes an asynchronous input into the sys_clk domain and flags rising
// edges. Usable for any slow asynchronous input (signals under test, buttons, ...).
//   sys_clk  - clock
//   rst      - asynchronous active-high reset
//   async_in - asynchronous input
//   level    - synchronized level (last synchronizer stage)
//   rise     - one-cycle pulse, SYNC_STAGES+1 cycles after the input rises
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic sys_clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of sig_in over GATE_CYCLES sys_clk
// cycles and reports the count once per gate; with the default 1 s gate at 100 MHz the result
// reads directly in Hz.
//   sys_clk - system clock
//   rst     - asynchronous active-high reset
//   sig_in  - asynchronous signal under measurement
//   bus     - freq_meter_if.slave: start/cont in; busy/freq_out/freq_valid/overflow out
// Optional: define FREQ_METER_DUTY_EN to add bus.high_cnt, the number of gate cycles in which
// the synchronized input was high (duty = high_cnt / GATE_CYCLES).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam int unsigned GateW = gate_cnt_w(GATE_CYCLES);
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);

  localparam logic [1:0] StIdle = 2'(IDLE);
  localparam logic [1:0] StGate = 2'(GATE);
  localparam logic [1:0] StDone = 2'(DONE);

  if (GATE_CYCLES < 2 || CNT_W < 1) begin : g_param_check
    $fatal(1, "freq_meter: GATE_CYCLES must be >= 2 and CNT_W >= 1");
  end

  logic sig_level;
  logic sig_rise;

`ifdef FREQ_METER_DUTY_EN
  sync_edge_det u_sync (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .async_in (sig_in),
    .level    (sig_level),
    .rise     (sig_rise)
  );
`else
  sync_edge_det u_sync (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .async_in (sig_in),
    .level    (),
    .rise     (sig_rise)
  );
  assign sig_level = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] freq_out_q;
  logic             overflow_q;
  logic             valid_q;
  logic             latch;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    latch      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end
      end
      StGate: begin
        gate_cnt_d = gate_cnt_q + GateW'(1);
        if (sig_rise) begin
          if (&edge_cnt_q) ovf_acc_d = 1'b1;
          else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        if (gate_cnt_q == GateLast) begin
          state_d = StDone;
          // Latch the next-state count so an edge in the last gate cycle is included.
          latch   = 1'b1;
        end
      end
      StDone: begin
        if (bus.cont) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_acc_q  <= 1'b0;
      freq_out_q <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      valid_q    <= latch;
      if (latch) begin
        freq_out_q <= edge_cnt_d;
        overflow_q <= ovf_acc_d;
      end
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.freq_out   = freq_out_q;
  assign bus.freq_valid = valid_q;
  assign bus.overflow   = overflow_q;

`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] high_cnt_q;

  always_comb begin
    hi_acc_d = hi_acc_q;
    if ((state_q == StIdle && bus.start) || (state_q == StDone && bus.cont)) begin
      hi_acc_d = '0;
    end else if (state_q == StGate && sig_level && !(&hi_acc_q)) begin
      hi_acc_d = hi_acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hi_acc_q   <= '0;
      high_cnt_q <= '0;
    end else begin
      hi_acc_q <= hi_acc_d;
      if (latch) high_cnt_q <= hi_acc_d;
    end
  end

  assign bus.high_cnt = high_cnt_q;
`else
  logic unused_level;
  assign unused_level = sig_level;
`endif

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter. It is the measuring counterpart of the system clock divider: the divider turns a count into a frequency, and this block turns an unknown frequency back into a count.
- Counts rising edges of an asynchronous input over a fixed gate of sys_clk cycles and reports the count once per gate.
- Sits beside the DDS core to measure generated or external waveforms (e.g. comparator output of the DAC).
- With the default 1 s gate at 100 MHz, the result reads directly in Hz.

Parameters:
- GATE_CYCLES, 100000000, gate length in sys_clk cycles; must be >= 2.
- CNT_W, 28, width of the edge counter and result.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  request one measurement; sampled only in IDLE.
- cont  input  1  continuous mode; sampled in DONE.
- busy  output  1  high in GATE and DONE.
- freq_out  output  CNT_W  latched edge count of the last completed gate.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- overflow  output  1  last completed gate saturated the counter.

Behaviour:
- One clock, sys_clk. Reset is asynchronous and active-high on rst; all flops clear immediately.
- Reset values: freq_out=0, freq_valid=0, overflow=0, busy=0, synchronizer stages=0, state=IDLE, counters=0.
- Input conditioning:
  - 2-flop synchronizer on sig_in, then a third flop for history.
  - edge = s2 & ~s3, so a rising edge is detected 3 sys_clk cycles after it occurs.
  - Maximum valid input frequency is < sys_clk/2. Higher input frequencies alias; no check is made.
- FSM states: IDLE, GATE, DONE.
  - IDLE: busy=0. If start=1, clear edge_cnt and gate_cnt, set ovf_acc=0, and go to GATE next cycle.
  - GATE: lasts exactly GATE_CYCLES cycles. gate_cnt counts 0..GATE_CYCLES-1. Every cycle with edge=1 increments edge_cnt, including the last GATE cycle. When gate_cnt==GATE_CYCLES-1, go to DONE.
  - DONE: lasts one cycle.
    - On entry, freq_out <= final edge_cnt (including any edge in the last GATE cycle) and overflow <= ovf_acc.
    - freq_valid=1 for exactly this cycle.
    - If cont=1, go to GATE (counters cleared, ovf_acc cleared); else go to IDLE.
- Continuous mode: valid pulses repeat every GATE_CYCLES+1 cycles. An edge during the DONE cycle is not counted; this one-cycle dead time is documented behaviour.
- Saturation: if edge_cnt is all-ones and edge=1, edge_cnt holds at all-ones and ovf_acc <= 1.
- start asserted in GATE or DONE is ignored; it is not queued.
- freq_out and overflow hold their values until the next DONE.
- Gate counter width is $clog2(GATE_CYCLES).
- Elaboration check: fatal if GATE_CYCLES < 2 or CNT_W < 1.
- Reset mid-gate aborts the measurement. No freq_valid is produced, and freq_out returns to 0.

Optional Feature:
- Macro: FREQ_METER_DUTY_EN.
- Defined:
  - Adds output high_cnt [CNT_W-1:0], reset value 0.
  - During GATE, a second saturating counter increments every cycle s2=1.
  - It is latched into high_cnt in DONE, alongside freq_out, under the same freq_valid pulse.
  - Duty = high_cnt/GATE_CYCLES, computed by software.
- Not defined: port and counter are absent; everything else is identical.

Decomposition:
- Package freq_meter_pkg holds:
  - typedef enum logic [1:0] {IDLE, GATE, DONE} fm_state_t;
  - constants DEF_GATE_CYCLES=100000000, DEF_CNT_W=28, SYNC_STAGES=2.
- One sub-module: sync_edge_det. It contains the 2-flop synchronizer, the history flop and the rising-edge pulse, exposes level (s2) and rise outputs, and uses the same sys_clk/rst. It is reusable for other asynchronous inputs such as buttons.

Test Plan:
- GATE_CYCLES=1000, sig_in period 10 cycles (5 high, 5 low), start pulse -> after 1001 cycles from start, freq_valid for 1 cycle, freq_out in {99,100}, overflow=0, busy falls the cycle after.
- sig_in held 0 (and separately held 1), single start -> freq_out=0, freq_valid exactly once, returns to IDLE.
- CNT_W=4, GATE_CYCLES=1000, sig_in period 20 cycles (50 edges) -> freq_out=15, overflow=1. Next gate with sig_in=0 -> freq_out=0, overflow=0.
- cont=1, GATE_CYCLES=1000, sig_in period 8 cycles -> freq_valid every 1001 cycles, each freq_out in {124,125}. Deasserting cont -> exactly one more valid, then IDLE.
- Assert rst at gate cycle 500 -> all outputs 0 immediately (asynchronous), no freq_valid. start after release -> normal result.
- start pulsed repeatedly during GATE -> ignored: a single valid per measurement, and gate length unchanged at 1000 cycles.
- With FREQ_METER_DUTY_EN, 30% duty input (3 high/7 low, period 10), GATE_CYCLES=1000 -> high_cnt in {299,300,301}.
